// File: rtl/pwm_multi_core.sv
// Multi-channel PWM engine. It has a prescaler, a programmable period, duty registers that are
// shadowed and applied at period boundaries, and a command-loss watchdog that forces a failsafe duty.
module pwm_multi_core #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int PRESC_W      = 8,
  parameter int WDOG_PERIODS = 50,
  parameter logic [CNT_W-1:0] FS_DUTY = '0
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              cfg_re,
  output logic [31:0]       cfg_rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic              failsafe
);

  localparam int WD_W = (WDOG_PERIODS < 2) ? 1 : $clog2(WDOG_PERIODS + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_PERIODS);
  localparam bit WD_ENABLE = (WDOG_PERIODS != 0);

  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   periodSh_q, periodSh_d;
  logic [CNT_W-1:0]   periodAct_q, periodAct_d;
  logic [CNT_W-1:0]   dutySh_q [NUM_CH];
  logic [CNT_W-1:0]   dutySh_d [NUM_CH];
  logic [CNT_W-1:0]   dutyAct_q [NUM_CH];
  logic [CNT_W-1:0]   dutyAct_d [NUM_CH];
  logic [PRESC_W-1:0] prescCnt_q, prescCnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               failsafe_q, failsafe_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [31:0]        rdata_q, rdata_d;

  logic              tick, wrap, loadAct, fsClr, anyDutyWr;
  logic [31:0]       rdVal;
  logic              unusedWdata;

  assign unusedWdata = ^cfg_wdata;

  always_comb begin
    en_d        = en_q;
    presc_d     = presc_q;
    periodSh_d  = periodSh_q;
    prescCnt_d  = prescCnt_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    rdVal       = '0;
    fsClr       = 1'b0;
    anyDutyWr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      dutySh_d[i]  = dutySh_q[i];
      dutyAct_d[i] = dutyAct_q[i];
      pwm_d[i]     = 1'b0;
    end

    // >= rather than == so lowering PRESCALE mid-count cannot stall the counter for 2^PRESC_W clocks
    tick = en_q && (prescCnt_q >= presc_q);
    wrap = tick && (cnt_q == periodAct_q);

    if (cfg_we) begin
      case (cfg_addr)
        4'd0: begin
          en_d  = cfg_wdata[0];
          fsClr = cfg_wdata[1];
        end
        4'd1: presc_d    = cfg_wdata[PRESC_W-1:0];
        4'd2: periodSh_d = cfg_wdata[CNT_W-1:0];
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == 4'(i + 4)) begin
              dutySh_d[i] = cfg_wdata[CNT_W-1:0];
              anyDutyWr   = 1'b1;
            end
          end
        end
      endcase
    end

    if (!en_q) begin
      prescCnt_d = '0;
      cnt_d      = '0;
    end else if (tick) begin
      prescCnt_d = '0;
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    end else begin
      prescCnt_d = prescCnt_q + 1'b1;
    end

    // A DUTY write or a clear beats a same-cycle period increment; the count saturates at the trip level
    if (anyDutyWr || fsClr) begin
      wd_d = '0;
    end else if (wrap && (wd_q < WD_MAX)) begin
      wd_d = wd_q + 1'b1;
    end
    failsafe_d = fsClr ? 1'b0 : (failsafe_q || (WD_ENABLE && (wd_d == WD_MAX)));

    // The actives see the old shadows on the wrap cycle, so a write on that cycle waits one more period
    loadAct     = !en_q || wrap;
    periodAct_d = loadAct ? periodSh_q : periodAct_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (loadAct) begin
        dutyAct_d[i] = failsafe_d ? FS_DUTY : dutySh_q[i];
      end
      pwm_d[i] = en_q && (cnt_q < dutyAct_q[i]);
    end

    case (cfg_addr)
      4'd0: rdVal[0]         = en_q;
      4'd1: rdVal[PRESC_W-1:0] = presc_q;
      4'd2: rdVal[CNT_W-1:0] = periodSh_q;
      4'd3: rdVal[0]         = failsafe_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg_addr == 4'(i + 4)) rdVal[CNT_W-1:0] = dutySh_q[i];
        end
      end
    endcase
    if (cfg_re) rdata_d = rdVal;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      en_q        <= 1'b0;
      presc_q     <= '0;
      periodSh_q  <= '0;
      periodAct_q <= '0;
      prescCnt_q  <= '0;
      cnt_q       <= '0;
      pwm_q       <= '0;
      failsafe_q  <= 1'b0;
      wd_q        <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dutySh_q[i]  <= '0;
        dutyAct_q[i] <= '0;
      end
    end else begin
      en_q        <= en_d;
      presc_q     <= presc_d;
      periodSh_q  <= periodSh_d;
      periodAct_q <= periodAct_d;
      prescCnt_q  <= prescCnt_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      failsafe_q  <= failsafe_d;
      wd_q        <= wd_d;
      rdata_q     <= rdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        dutySh_q[i]  <= dutySh_d[i];
        dutyAct_q[i] <= dutyAct_d[i];
      end
    end
  end

  assign cfg_rdata   = rdata_q;
  assign pwm_out     = pwm_q;
  assign period_tick = wrap;
  assign failsafe    = failsafe_q;

endmodule
